// File: rtl/rx_pkg.sv
// Shared constants, FSM encoding and carrier template for the receive demodulator.
// Pure definitions; no latency, no flow control.
package rx_pkg;

    localparam int SAMPLES_PER_CYCLE_DEF = 8;
    localparam int CYCLES_PER_BIT_DEF    = 5;
    localparam int NBITS_DEF             = 1024;
    localparam int CONF_MARGIN_DEF       = 8;

    localparam int SAMPLES_PER_BIT = SAMPLES_PER_CYCLE_DEF * CYCLES_PER_BIT_DEF;
    localparam int SCORE_W         = $clog2(SAMPLES_PER_BIT + 1);
    localparam int LOWCONF_W       = 11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A '1' bit is high for the first half of every carrier period.
    function automatic logic template_bit(input int unsigned phase, input int unsigned spc);
        return (phase < (spc / 2));
    endfunction

endpackage

// File: rtl/rx_bit_correlator.sv
// Counts samples matching the '1' template over one bit; o_match is the current sample.
// Accumulator updates one cycle after an enabled sample; frozen while i_enable is low.
module rx_bit_correlator
    import rx_pkg::*;
#(
    parameter int SAMPLES_PER_CYCLE = SAMPLES_PER_CYCLE_DEF,
    parameter int PH_W              = $clog2(SAMPLES_PER_CYCLE_DEF)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PH_W-1:0]    i_phase,
    input  logic               i_sample,
    input  logic               i_enable,
    input  logic               i_clear,
    output logic               o_match,
    output logic [SCORE_W-1:0] o_match_count
);

    logic [SCORE_W-1:0] r_acc;
    logic               w_template;

    assign w_template    = template_bit(32'(i_phase), SAMPLES_PER_CYCLE);
    assign o_match       = (i_sample == w_template);
    assign o_match_count = r_acc;

    // Clear wins over enable so the last sample of a bit never leaks into the next one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= r_acc + SCORE_W'(o_match);
        end
    end

endmodule

// File: rtl/rx_demodulator.sv
// Recovers a frame of bits from the sampled carrier by template correlation; obit_valid 1 cycle after a bit's last sample.
// ienable low freezes all state and suppresses strobes; no other backpressure.
module rx_demodulator
    import rx_pkg::*;
#(
    parameter int SAMPLES_PER_CYCLE = SAMPLES_PER_CYCLE_DEF,
    parameter int CYCLES_PER_BIT    = CYCLES_PER_BIT_DEF,
    parameter int NBITS             = NBITS_DEF,
    parameter int CONF_MARGIN       = CONF_MARGIN_DEF
) (
    input  logic                 crx_clk,
    input  logic                 rrx_rst,
    input  logic                 ienable,
    input  logic                 istart_interrupt,
    input  logic                 isample,
    output logic                 obit,
    output logic                 obit_valid,
    output logic [SCORE_W-1:0]   oscore,
    output logic [NBITS-1:0]     obinary_sequence,
    output logic [LOWCONF_W-1:0] olow_conf_count,
    output logic                 obusy,
    output logic                 odone
);

    localparam int SPB   = SAMPLES_PER_CYCLE * CYCLES_PER_BIT;
    localparam int HALF  = SPB / 2;
    localparam int PH_W  = $clog2(SAMPLES_PER_CYCLE);
    localparam int PER_W = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W = $clog2(NBITS);

    logic [1:0]           r_state;
    logic [PH_W-1:0]      r_phase;
    logic [PER_W-1:0]     r_period;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 r_bit;
    logic                 r_bit_valid;
    logic [SCORE_W-1:0]   r_score;
    logic [NBITS-1:0]     r_seq;
    logic [LOWCONF_W-1:0] r_low_cnt;
    logic                 r_done;

    logic                 w_run_en;
    logic                 w_start;
    logic                 w_phase_last;
    logic                 w_period_last;
    logic                 w_bit_last;
    logic                 w_bit_end;
    logic                 w_match;
    logic [SCORE_W-1:0]   w_match_count;
    logic [SCORE_W-1:0]   w_score;
    logic                 w_decision;
    logic                 w_low_conf;

    assign w_run_en      = (r_state == ST_RUN) && ienable;
    assign w_start       = (r_state == ST_IDLE) && ienable && istart_interrupt;
    assign w_phase_last  = (r_phase == PH_W'(SAMPLES_PER_CYCLE - 1));
    assign w_period_last = (r_period == PER_W'(CYCLES_PER_BIT - 1));
    assign w_bit_last    = (r_bit_idx == BIT_W'(NBITS - 1));
    assign w_bit_end     = w_run_en && w_phase_last && w_period_last;

    rx_bit_correlator #(
        .SAMPLES_PER_CYCLE (SAMPLES_PER_CYCLE),
        .PH_W              (PH_W)
    ) u_corr (
        .i_clk         (crx_clk),
        .i_rst_n       (rrx_rst),
        .i_phase       (r_phase),
        .i_sample      (isample),
        .i_enable      (w_run_en),
        .i_clear       (w_start || w_bit_end),
        .o_match       (w_match),
        .o_match_count (w_match_count)
    );

    // Score includes the sample being taken this cycle, so the decision lands one cycle after it.
    assign w_score    = w_match_count + SCORE_W'(w_match);
    assign w_decision = (w_score >= SCORE_W'(HALF));
    assign w_low_conf = (w_score > SCORE_W'(HALF - CONF_MARGIN)) &&
                        (w_score < SCORE_W'(HALF + CONF_MARGIN));

    always_ff @(posedge crx_clk) begin
        if (!rrx_rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_period    <= '0;
            r_bit_idx   <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_score     <= '0;
            r_seq       <= '0;
            r_low_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_RUN;
                        r_phase   <= '0;
                        r_period  <= '0;
                        r_bit_idx <= '0;
                        r_seq     <= '0;
                        r_low_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (ienable) begin
                        if (w_phase_last) begin
                            r_phase <= '0;
                            if (w_period_last) begin
                                r_period <= '0;
                            end else begin
                                r_period <= r_period + PER_W'(1);
                            end
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                    if (w_bit_end) begin
                        r_bit              <= w_decision;
                        r_bit_valid        <= 1'b1;
                        r_score            <= w_score;
                        r_seq[r_bit_idx]   <= w_decision;
                        if (w_low_conf && (r_low_cnt != '1)) begin
                            r_low_cnt <= r_low_cnt + LOWCONF_W'(1);
                        end
                        if (w_bit_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign obit             = r_bit;
    assign obit_valid       = r_bit_valid;
    assign oscore           = r_score;
    assign obinary_sequence = r_seq;
    assign olow_conf_count  = r_low_cnt;
    assign obusy            = (r_state == ST_RUN);
    assign odone            = r_done;

endmodule

// File: tb/tb_rx_demodulator.sv
// Directed bench for rx_demodulator on a short 16-bit frame: clean, all-ones, noisy, paused, reset and restart cases.
module tb_rx_demodulator;

    localparam int NB  = 16;
    localparam int SPB = 40;

    logic          crx_clk = 1'b0;
    logic          rrx_rst = 1'b0;
    logic          ienable = 1'b0;
    logic          istart_interrupt = 1'b0;
    logic          isample = 1'b0;
    logic          obit;
    logic          obit_valid;
    logic [5:0]    oscore;
    logic [NB-1:0] obinary_sequence;
    logic [10:0]   olow_conf_count;
    logic          obusy;
    logic          odone;

    rx_demodulator #(.NBITS(NB)) dut (
        .crx_clk          (crx_clk),
        .rrx_rst          (rrx_rst),
        .ienable          (ienable),
        .istart_interrupt (istart_interrupt),
        .isample          (isample),
        .obit             (obit),
        .obit_valid       (obit_valid),
        .oscore           (oscore),
        .obinary_sequence (obinary_sequence),
        .olow_conf_count  (olow_conf_count),
        .obusy            (obusy),
        .odone            (odone)
    );

    always #5 crx_clk = ~crx_clk;

    int cyc = 0;
    always @(posedge crx_clk) cyc <= cyc + 1;

    int         n_valid = 0;
    int         n_done = 0;
    int         n_bad = 0;
    int         last_valid_cyc = 0;
    int         done_cyc = 0;
    logic [5:0] score_log [64];

    always @(negedge crx_clk) begin
        if (obit_valid) begin
            score_log[n_valid % 64] = oscore;
            if (oscore != 6'd0 && oscore != 6'd40) n_bad++;
            last_valid_cyc = cyc;
            n_valid++;
        end
        if (odone) begin
            done_cyc = cyc;
            n_done++;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int flip_tab [NB];
    int pause_bit;
    int pause_len;
    int restart_bit;
    int start_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic en, input logic st, input logic s);
        @(posedge crx_clk);
        #2;
        rrx_rst          = rst_n;
        ienable          = en;
        istart_interrupt = st;
        isample          = s;
    endtask

    task automatic clear_tab();
        for (int k = 0; k < NB; k++) flip_tab[k] = 0;
        pause_bit   = -1;
        pause_len   = 0;
        restart_bit = -1;
    endtask

    // Bit of '1' = 11110000 x5, '0' = inverse; first flip_tab[k] samples inverted.
    task automatic send_bit(input int k, input logic b);
        for (int i = 0; i < SPB; i++) begin
            logic t;
            logic s;
            if (k == pause_bit && i == 17) begin
                repeat (pause_len) drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
            t = ((i % 8) < 4);
            s = b ? t : ~t;
            if (i < flip_tab[k]) s = ~s;
            drive(1'b1, 1'b1, (k == restart_bit && i == 0), s);
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] w);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        start_cyc = cyc;
        for (int k = 0; k < NB; k++) send_bit(k, w[k]);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int v0;
        int d0;
        int b0;
        logic [NB-1:0] pat;

        clear_tab();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_obit", 64'(obit), 64'd0);
        check("rst_obit_valid", 64'(obit_valid), 64'd0);
        check("rst_oscore", 64'(oscore), 64'd0);
        check("rst_seq", 64'(obinary_sequence), 64'd0);
        check("rst_lowconf", 64'(olow_conf_count), 64'd0);
        check("rst_obusy", 64'(obusy), 64'd0);
        check("rst_odone", 64'(odone), 64'd0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Clean frame
        pat = 16'hA5C3;
        v0 = n_valid; d0 = n_done; b0 = n_bad;
        send_frame(pat);
        check("clean_word", 64'(obinary_sequence), 64'(pat));
        check("clean_lowconf", 64'(olow_conf_count), 64'd0);
        check("clean_strobes", 64'(n_valid - v0), 64'(NB));
        check("clean_scores_extreme", 64'(n_bad - b0), 64'd0);
        check("clean_done_latency", 64'(done_cyc - start_cyc), 64'(2 + SPB * NB));
        check("clean_done_after_last", 64'(done_cyc - last_valid_cyc), 64'd1);
        check("clean_done_count", 64'(n_done - d0), 64'd1);
        check("clean_busy_after", 64'(obusy), 64'd0);

        // All-ones frame
        v0 = n_valid; d0 = n_done;
        send_frame('1);
        check("ones_word", 64'(obinary_sequence), 64'(16'hFFFF));
        check("ones_strobes", 64'(n_valid - v0), 64'(NB));
        check("ones_done_after_last", 64'(done_cyc - last_valid_cyc), 64'd1);
        check("ones_score_last", 64'(score_log[(v0 + NB - 1) % 64]), 64'd40);

        // Bit 7 with 15 flips: score 25
        clear_tab();
        flip_tab[7] = 15;
        v0 = n_valid;
        send_frame(16'h3C96);
        check("noise15_word", 64'(obinary_sequence), 64'(16'h3C96));
        check("noise15_lowconf", 64'(olow_conf_count), 64'd1);
        check("noise15_score", 64'(score_log[(v0 + 7) % 64]), 64'd25);

        // Thresholds: tie 20 -> 1, 19 -> 0, 12/28 outside low-confidence band, 13 inside
        clear_tab();
        flip_tab[7] = 20;
        flip_tab[4] = 21;
        flip_tab[3] = 12;
        flip_tab[0] = 13;
        flip_tab[1] = 12;
        v0 = n_valid;
        send_frame(16'h3C96);
        check("noise20_word", 64'(obinary_sequence), 64'(16'h3C86));
        check("noise20_bit7", 64'(obinary_sequence[7]), 64'd1);
        check("noise20_lowconf", 64'(olow_conf_count), 64'd3);
        check("noise20_score7", 64'(score_log[(v0 + 7) % 64]), 64'd20);
        check("noise20_score4", 64'(score_log[(v0 + 4) % 64]), 64'd19);
        check("noise20_score3", 64'(score_log[(v0 + 3) % 64]), 64'd12);
        check("noise20_score0", 64'(score_log[(v0 + 0) % 64]), 64'd13);
        check("noise20_score1", 64'(score_log[(v0 + 1) % 64]), 64'd28);

        // ienable low for 10 cycles inside bit 10
        clear_tab();
        pause_bit = 10;
        pause_len = 10;
        v0 = n_valid;
        send_frame(pat);
        check("pause_word", 64'(obinary_sequence), 64'(pat));
        check("pause_done_latency", 64'(done_cyc - start_cyc), 64'(2 + SPB * NB + 10));
        check("pause_strobes", 64'(n_valid - v0), 64'(NB));

        // Reset after bit 7 of a frame
        clear_tab();
        d0 = n_done;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) send_bit(k, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("prerst_busy", 64'(obusy), 64'd1);
        check("prerst_word", 64'(obinary_sequence), 64'(16'h00FF));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_seq", 64'(obinary_sequence), 64'd0);
        check("midrst_obit", 64'(obit), 64'd0);
        check("midrst_oscore", 64'(oscore), 64'd0);
        check("midrst_busy", 64'(obusy), 64'd0);
        check("midrst_lowconf", 64'(olow_conf_count), 64'd0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("midrst_still_idle", 64'(obusy), 64'd0);
        check("midrst_no_done", 64'(n_done - d0), 64'd0);
        send_frame(16'h1234);
        check("postrst_word", 64'(obinary_sequence), 64'(16'h1234));
        check("postrst_done_latency", 64'(done_cyc - start_cyc), 64'(2 + SPB * NB));

        // Start pulse during RUN at bit 5 is ignored
        clear_tab();
        restart_bit = 5;
        d0 = n_done;
        send_frame(16'hBEEF);
        check("restart_word", 64'(obinary_sequence), 64'(16'hBEEF));
        check("restart_done_count", 64'(n_done - d0), 64'd1);
        check("restart_done_latency", 64'(done_cyc - start_cyc), 64'(2 + SPB * NB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
